// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice: FSM encoding,
// exception-vector location and wait-counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    localparam int unsigned VEC_BYTE_ADDR    = 252;
    localparam logic [31:0] VEC_WORD_DEFAULT = 32'h0000_FEFF;
    localparam int unsigned WAIT_CNT_W       = 4;

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_resp_if;

    logic        req;
    logic        wr;
    logic [31:0] address;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        ready;
    logic        addr_err;

    modport master (
        output req, wr, address, datain,
        input  dataout, ready, addr_err
    );

    modport slave (
        input  req, wr, address, datain,
        output dataout, ready, addr_err
    );

endinterface

// File: rtl/mem_resp_array.sv
// Word storage with asynchronous reset; the exception-vector word resets to
// VEC_WORD and ignores writes.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] VEC_WORD    = VEC_WORD_DEFAULT,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    localparam int unsigned VEC_IDX = VEC_BYTE_ADDR / 4;

    logic [31:0] mem_q [DEPTH_WORDS];

    function automatic logic [31:0] reset_word(input int unsigned i);
        return (i == VEC_IDX) ? VEC_WORD : 32'h0;
    endfunction

    // NOTE: every word is reset explicitly, which keeps storage in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[IDX_W'(i)] <= reset_word(i);
            end
        end else if (we && (32'(idx) != VEC_IDX)) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE/BUSY/RESP handshake with WAIT_CYCLES
// wait states. Define MEM_RESP_ALIGN_CHECK_EN to reject misaligned addresses.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] VEC_WORD    = VEC_WORD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mem_resp_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT =
        WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  wr_q, wr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  addr_err_q, addr_err_d;
    logic [31:0]           dataout_q, dataout_d;

    logic        txn_wr;
    logic [31:0] txn_addr;
    logic [31:0] txn_data;
    logic        misaligned;
    logic        reject;
    logic        enter_resp;
    logic        mem_we;
    logic [31:0] rd_word;

    // With zero wait states the commit edge is the acceptance edge, so the live inputs apply.
    assign txn_wr   = (state_q == ST_IDLE) ? bus.wr      : wr_q;
    assign txn_addr = (state_q == ST_IDLE) ? bus.address : addr_q;
    assign txn_data = (state_q == ST_IDLE) ? bus.datain  : data_q;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign misaligned = (txn_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign reject = (txn_addr >= ADDR_LIMIT) || misaligned;

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        dataout_d  = dataout_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    wr_d       = bus.wr;
                    addr_d     = bus.address;
                    data_d     = bus.datain;
                    wait_cnt_d = '0;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            ready_d    = 1'b1;
            addr_err_d = reject;
            if (reject) begin
                dataout_d = '0;
            end else if (!txn_wr) begin
                dataout_d = rd_word;
            end else begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            dataout_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            dataout_q  <= dataout_d;
        end
    end

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .VEC_WORD    (VEC_WORD)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .idx   (txn_addr[IDX_W+1:2]),
        .wdata (txn_data),
        .rdata (rd_word)
    );

    assign bus.dataout  = dataout_q;
    assign bus.ready    = ready_q;
    assign bus.addr_err = addr_err_q;

endmodule
